// File: rtl/truth_table_sweeper.sv
// Walks the 16 minterms of a 4-input function, samples its output, builds
// the truth table, counts ones and compares against a golden table.
module truth_table_sweeper #(
    parameter int SETTLE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        s,
    output logic [3:0]  m,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  ones,
    output logic        mismatch,
    output logic [3:0]  first_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] SETTLE_L = 3'(SETTLE);

    // Handshake: start is a level request sampled only in IDLE; done is a
    // single-cycle pulse and busy covers exactly the RUN cycles.
    state_t      state_q, state_d;
    logic [2:0]  settle_cnt;
    logic [15:0] expected_q;
    logic        sample_edge;

    assign sample_edge = (state_q == RUN) && (settle_cnt == SETTLE_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (sample_edge && (m == 4'd15)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign x = m[3];
    assign y = m[2];
    assign w = m[1];
    assign z = m[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            m           <= 4'd0;
            settle_cnt  <= 3'd0;
            expected_q  <= 16'd0;
            truth_table <= 16'd0;
            ones        <= 5'd0;
            mismatch    <= 1'b0;
            first_err   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m           <= 4'd0;
                        settle_cnt  <= 3'd0;
                        expected_q  <= expected;
                        truth_table <= 16'd0;
                        ones        <= 5'd0;
                        mismatch    <= 1'b0;
                        first_err   <= 4'd0;
                    end
                end
                RUN: begin
                    if (sample_edge) begin
                        truth_table[m] <= s;
                        if (s) ones <= ones + 5'd1;
                        // Only the lowest failing minterm is recorded.
                        if ((s != expected_q[m]) && !mismatch) begin
                            mismatch  <= 1'b1;
                            first_err <= m;
                        end
                        if (m != 4'd15) begin
                            m          <= m + 4'd1;
                            settle_cnt <= 3'd0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two instances (SETTLE=0 and SETTLE=3) sweep the same
// function; results are checked against hand-computed tables.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start3 = 1'b0;
    logic [15:0] expected = 16'd0;
    logic        use3 = 1'b0;

    int total = 0;
    int bad = 0;

    logic [3:0]  m0, m3, fe0, fe3;
    logic        x0, y0, w0, z0, x3, y3, w3, z3;
    logic        busy0, done0, busy3, done3, mm0, mm3;
    logic [15:0] tt0, tt3;
    logic [4:0]  ones0, ones3;
    logic        s0, s3;

    assign s0 = (~y0 | ~z0) & (~x0 | ~w0 | ~z0) & (x0 | ~w0 | z0);
    assign s3 = (~y3 | ~z3) & (~x3 | ~w3 | ~z3) & (x3 | ~w3 | z3);

    truth_table_sweeper #(.SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .expected(expected), .s(s0),
        .m(m0), .x(x0), .y(y0), .w(w0), .z(z0), .busy(busy0), .done(done0),
        .truth_table(tt0), .ones(ones0), .mismatch(mm0), .first_err(fe0)
    );

    truth_table_sweeper #(.SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .expected(expected), .s(s3),
        .m(m3), .x(x3), .y(y3), .w(w3), .z(z3), .busy(busy3), .done(done3),
        .truth_table(tt3), .ones(ones3), .mismatch(mm3), .first_err(fe3)
    );

    logic [3:0]  m_s, fe_s;
    logic        busy_s, done_s, mm_s;
    logic [15:0] tt_s;
    logic [4:0]  ones_s;

    assign m_s    = use3 ? m3 : m0;
    assign fe_s   = use3 ? fe3 : fe0;
    assign busy_s = use3 ? busy3 : busy0;
    assign done_s = use3 ? done3 : done0;
    assign mm_s   = use3 ? mm3 : mm0;
    assign tt_s   = use3 ? tt3 : tt0;
    assign ones_s = use3 ? ones3 : ones0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        check("xywz_eq_m0", {28'd0, x0, y0, w0, z0}, {28'd0, m0});
        check("xywz_eq_m3", {28'd0, x3, y3, w3, z3}, {28'd0, m3});
        check("done_busy_excl0", {31'd0, done0 & busy0}, 32'd0);
        check("done_busy_excl3", {31'd0, done3 & busy3}, 32'd0);
    end

    task automatic run_sweep(input logic sel3, input logic [15:0] exp_v,
                             input logic [15:0] want_tt, input int want_ones,
                             input logic want_mm, input int want_fe);
        int n, per, busy_cnt, done_at, m_err;
        per = sel3 ? 4 : 1;
        n = 16 * per;
        use3 = sel3;
        @(negedge clk);
        expected = exp_v;
        if (sel3) start3 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start3 = 1'b0;
        busy_cnt = 0;
        done_at = 0;
        m_err = 0;
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (busy_s) busy_cnt++;
            if (done_s && done_at == 0) done_at = c;
            if (c <= n && m_s != 4'((c - 1) / per)) m_err++;
        end
        check("busy_cycles", 32'(busy_cnt), 32'(n));
        check("done_cycle", 32'(done_at), 32'(n + 1));
        check("m_step", 32'(m_err), 32'd0);
        check("table", {16'd0, tt_s}, {16'd0, want_tt});
        check("ones", {27'd0, ones_s}, 32'(want_ones));
        check("mismatch", {31'd0, mm_s}, {31'd0, want_mm});
        check("first_err", {28'd0, fe_s}, 32'(want_fe));
        check("idle_after", {30'd0, busy_s, done_s}, 32'd0);
    endtask

    initial begin
        int found, done_cnt, pat_err;
        logic exp_busy, exp_done;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_m", {28'd0, m0}, 32'd0);
        check("rst_busy_done", {30'd0, busy0, done0}, 32'd0);
        check("rst_table", {16'd0, tt0}, 32'd0);
        check("rst_ones", {27'd0, ones0}, 32'd0);
        check("rst_mm_fe", {27'd0, mm0, fe0}, 32'd0);

        run_sweep(1'b0, 16'h571B, 16'h571B, 9, 1'b0, 0);
        run_sweep(1'b0, 16'hFFFF, 16'h571B, 9, 1'b1, 2);

        // Abort mid-sweep with reset, then reset beats start.
        use3 = 1'b0;
        @(negedge clk);
        expected = 16'h571B;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        found = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m0 == 4'd7) begin
                found = 1;
                break;
            end
        end
        check("abort_reached_m7", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_m", {28'd0, m0}, 32'd0);
        check("abort_busy_done", {30'd0, busy0, done0}, 32'd0);
        check("abort_table", {16'd0, tt0}, 32'd0);
        check("abort_ones", {27'd0, ones0}, 32'd0);
        start0 = 1'b1;
        @(negedge clk);
        check("reset_over_start", {31'd0, busy0}, 32'd0);
        reset = 1'b0;
        start0 = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Held start: back-to-back sweeps with one DONE and one IDLE cycle.
        @(negedge clk);
        expected = 16'h571B;
        start0 = 1'b1;
        pat_err = 0;
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 36) begin
                exp_busy = (c >= 1 && c <= 16) || (c >= 19 && c <= 34);
                exp_done = (c == 17) || (c == 35);
                if (busy0 != exp_busy || done0 != exp_done) pat_err++;
                if (done0) done_cnt++;
            end
            if (c == 36) begin
                check("held_table", {16'd0, tt0}, 32'h571B);
                check("held_ones", {27'd0, ones0}, 32'd9);
            end
        end
        start0 = 1'b0;
        check("held_pattern", 32'(pat_err), 32'd0);
        check("held_done_count", 32'(done_cnt), 32'd2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_sweep(1'b1, 16'h571B, 16'h571B, 9, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
